// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display interface.
// Patterns are {a,b,c,d,e,f,g} with a as MSB, active-low (0 = segment lit).
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } reader_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of one active-low 7-segment pattern into a BCD value.
// Blank and undecodable patterns both report value 0 and raise their own flag.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_value,
  output logic       o_blank,
  output logic       o_invalid
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    o_value   = 4'd0;
    o_blank   = 1'b0;
    o_invalid = 1'b0;
    case (i_pattern)
      SEG_0:     o_value = 4'd0;
      SEG_1:     o_value = 4'd1;
      SEG_2:     o_value = 4'd2;
      SEG_3:     o_value = 4'd3;
      SEG_4:     o_value = 4'd4;
      SEG_5:     o_value = 4'd5;
      SEG_6:     o_value = 4'd6;
      SEG_7:     o_value = 4'd7;
      SEG_8:     o_value = 4'd8;
      SEG_9:     o_value = 4'd9;
      SEG_BLANK: o_blank = 1'b1;
      default:   o_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_pattern_reader.sv
// Receiving end of a multiplexed 7-segment display: waits for each strobed
// pattern to be stable, decodes it and publishes per-digit values and flags.
module seg_pattern_reader
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    upd_valid,
  output logic [2:0]              upd_digit,
  output logic [3:0]              upd_value,
  output logic                    frame_done
);

  localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int SW = NUM_DIGITS + 7;

  reader_state_t           r_state;
  logic [CW-1:0]           r_cnt;
  logic [SW-1:0]           r_sample;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_upd_valid;
  logic [2:0]              r_upd_digit;
  logic [3:0]              r_upd_value;
  logic                    r_frame_done;

  logic [SW-1:0]         w_in;
  logic                  w_match;
  logic                  w_onehot;
  logic [2:0]            w_index;
  logic [3:0]            w_value;
  logic                  w_blank;
  logic                  w_invalid;
  logic                  w_capture;
  logic [NUM_DIGITS-1:0] w_mask_next;
  logic                  w_frame;

  seg_pattern_decode u_decode (
    .i_pattern (seg_n),
    .o_value   (w_value),
    .o_blank   (w_blank),
    .o_invalid (w_invalid)
  );

  assign w_in        = {digit_en, seg_n};
  assign w_match     = (w_in == r_sample);
  assign w_onehot    = (digit_en != '0) && ((digit_en & (digit_en - NUM_DIGITS'(1))) == '0);
  // A match while settling implies the strobe is the same one-hot value that started the window.
  assign w_capture   = (r_state == SETTLE) && w_match && (r_cnt == CW'(STABLE_CYCLES));
  assign w_mask_next = r_mask | digit_en;
  assign w_frame     = w_capture && (&w_mask_next);

  always_comb begin
    w_index = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_en[i]) w_index = w_index | 3'(i);
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sample     <= '1;
      r_mask       <= '0;
      r_digits     <= '0;
      r_blank      <= '1;
      r_err        <= '0;
      r_upd_valid  <= 1'b0;
      r_upd_digit  <= 3'd0;
      r_upd_value  <= 4'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_sample     <= w_in;
      r_upd_valid  <= w_capture;
      r_frame_done <= w_frame;
      // A fresh error wins over a simultaneous clear.
      r_err <= (err_clr ? '0 : r_err) | ((w_capture && w_invalid) ? digit_en : '0);

      case (r_state)
        IDLE: begin
          if (w_onehot) begin
            r_state <= SETTLE;
            r_cnt   <= CW'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        SETTLE: begin
          if (!w_onehot) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (!w_match) begin
            r_cnt <= CW'(1);
          end else if (r_cnt == CW'(STABLE_CYCLES)) begin
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (!w_match) begin
            if (w_onehot) begin
              r_state <= SETTLE;
              r_cnt   <= CW'(1);
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase

      if (w_capture) begin
        r_upd_digit <= w_index;
        r_upd_value <= (w_blank || w_invalid) ? 4'd0 : w_value;
        r_mask      <= w_frame ? '0 : w_mask_next;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (digit_en[i]) begin
            r_blank[i] <= w_blank;
            if (!w_invalid) r_digits[4*i +: 4] <= w_value;
          end
        end
      end
    end
  end

  assign digits     = r_digits;
  assign blank      = r_blank;
  assign err        = r_err;
  assign upd_valid  = r_upd_valid;
  assign upd_digit  = r_upd_digit;
  assign upd_value  = r_upd_value;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Self-checking bench for seg_pattern_reader: directed scenarios followed by
// randomized scans, all compared against a run-length reference model.
module tb_seg_pattern_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_n;
  logic [ND-1:0] digit_en;
  logic          err_clr;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] blank;
  logic [ND-1:0] err;
  logic          upd_valid;
  logic [2:0]    upd_digit;
  logic [3:0]    upd_value;
  logic          frame_done;

  seg_pattern_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_n      (seg_n),
    .digit_en   (digit_en),
    .err_clr    (err_clr),
    .digits     (digits),
    .blank      (blank),
    .err        (err),
    .upd_valid  (upd_valid),
    .upd_digit  (upd_digit),
    .upd_value  (upd_value),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a capture happens on the edge where an identical one-hot
  // input vector has been seen on SC+1 consecutive edges.
  logic [6:0]      pat_tab [0:9];
  logic [ND+6:0]   m_prev;
  int              m_run;
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_blank, m_err, m_mask;
  logic            m_valid, m_frame;
  logic [2:0]      m_idx;
  logic [3:0]      m_val;
  int              obs_valid, obs_frame;

  // Returns 0..9 for a digit, 10 for blank, 11 for anything else.
  function automatic int m_decode(input logic [6:0] p);
    if (p == 7'h7f) return 10;
    for (int k = 0; k < 10; k++) if (pat_tab[k] == p) return k;
    return 11;
  endfunction

  task automatic model_reset();
    m_prev   = '1;
    m_run    = 0;
    m_digits = '0;
    m_blank  = '1;
    m_err    = '0;
    m_mask   = '0;
    m_valid  = 1'b0;
    m_frame  = 1'b0;
    m_idx    = 3'd0;
    m_val    = 4'd0;
  endtask

  task automatic model_edge(input logic [ND-1:0] en, input logic [6:0] seg, input logic clr);
    logic [ND+6:0] vec;
    logic [ND-1:0] err_next;
    int            d;
    vec = {en, seg};
    if (vec == m_prev) m_run++;
    else m_run = 1;
    m_prev   = vec;
    err_next = clr ? '0 : m_err;
    m_valid  = ($countones(en) == 1) && (m_run == SC + 1);
    m_frame  = 1'b0;
    if (m_valid) begin
      for (int i = 0; i < ND; i++) if (en[i]) m_idx = 3'(i);
      d = m_decode(seg);
      m_val = (d < 10) ? 4'(d) : 4'd0;
      m_blank[m_idx] = (d == 10);
      if (d == 11) err_next[m_idx] = 1'b1;
      else m_digits[4*m_idx +: 4] = m_val;
      m_mask = m_mask | en;
      if (m_mask == '1) begin
        m_frame = 1'b1;
        m_mask  = '0;
      end
    end
    m_err = err_next;
  endtask

  task automatic check_outputs();
    check("upd_valid", 32'(upd_valid), 32'(m_valid));
    if (m_valid) begin
      check("upd_digit", 32'(upd_digit), 32'(m_idx));
      check("upd_value", 32'(upd_value), 32'(m_val));
    end
    check("frame_done", 32'(frame_done), 32'(m_frame));
    check("digits", 32'(digits), 32'(m_digits));
    check("blank", 32'(blank), 32'(m_blank));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic step(input logic [ND-1:0] en, input logic [6:0] seg, input logic clr);
    digit_en = en;
    seg_n    = seg;
    err_clr  = clr;
    @(posedge clk);
    model_edge(en, seg, clr);
    #1;
    if (upd_valid)  obs_valid++;
    if (frame_done) obs_frame++;
    check_outputs();
  endtask

  task automatic hold(input logic [ND-1:0] en, input logic [6:0] seg, input int n);
    for (int c = 0; c < n; c++) step(en, seg, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_blank"}, 32'(blank), 32'hf);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_valid"}, 32'(upd_valid), 32'h0);
    check({tag, "_udigit"}, 32'(upd_digit), 32'h0);
    check({tag, "_uvalue"}, 32'(upd_value), 32'h0);
    check({tag, "_frame"}, 32'(frame_done), 32'h0);
  endtask

  // Called at posedge+1; pulses rst between edges.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_values(tag);
    model_reset();
    #2 rst = 1'b0;
  endtask

  logic [4*ND-1:0] snap_digits;
  logic [ND-1:0]   snap_blank;

  initial begin
    pat_tab[0] = 7'b0000001; pat_tab[1] = 7'b1001111; pat_tab[2] = 7'b0010010;
    pat_tab[3] = 7'b0000110; pat_tab[4] = 7'b1001100; pat_tab[5] = 7'b0100100;
    pat_tab[6] = 7'b0100000; pat_tab[7] = 7'b0001111; pat_tab[8] = 7'b0000000;
    pat_tab[9] = 7'b0000100;

    rst = 1'b1; digit_en = '0; seg_n = '1; err_clr = 1'b0;
    obs_valid = 0; obs_frame = 0;
    #1 check_reset_values("init");
    model_reset();
    #13 rst = 1'b0;

    // Reset in the middle of a settle window aborts the capture.
    hold(4'b0100, 7'b0010010, 2);
    async_reset("midreset");
    obs_valid = 0;
    hold(4'b0100, 7'b0010010, SC);
    check("midreset_no_early_valid", 32'(obs_valid), 32'd0);
    hold(4'b0100, 7'b0010010, 1);
    check("midreset_late_valid", 32'(obs_valid), 32'd1);

    // Basic capture of value 3 on digit 0.
    obs_valid = 0;
    hold(4'b0001, 7'b0000110, 5);
    check("basic_valid_count", 32'(obs_valid), 32'd1);
    check("basic_digit0", 32'(digits[3:0]), 32'd3);
    check("basic_blank0", 32'(blank[0]), 32'd0);

    // Full frame 1,2,8,9.
    obs_valid = 0; obs_frame = 0;
    hold(4'b0001, 7'b1001111, 6);
    hold(4'b0010, 7'b0010010, 6);
    hold(4'b0100, 7'b0000000, 6);
    hold(4'b1000, 7'b0000100, 6);
    check("frame_valid_count", 32'(obs_valid), 32'd4);
    check("frame_done_count", 32'(obs_frame), 32'd1);
    check("frame_digits", 32'(digits), 32'h9821);
    check("frame_blank", 32'(blank), 32'h0);

    // One-cycle glitch restarts the stability window.
    obs_valid = 0;
    hold(4'b0100, 7'b0100100, 3);
    hold(4'b0100, 7'b0000000, 1);
    hold(4'b0100, 7'b0100100, SC);
    check("glitch_no_early", 32'(obs_valid), 32'd0);
    hold(4'b0100, 7'b0100100, 1);
    check("glitch_capture", 32'(obs_valid), 32'd1);
    check("glitch_value", 32'(digits[11:8]), 32'd5);

    // Blank, error and clear/set collision on digit 1.
    hold(4'b0010, 7'b1111111, 6);
    check("blank1", 32'(blank[1]), 32'd1);
    check("blank1_digit", 32'(digits[7:4]), 32'd0);
    hold(4'b0010, 7'b0010010, 6);
    hold(4'b0010, 7'b1010101, 6);
    check("err1_set", 32'(err[1]), 32'd1);
    check("err1_digit_kept", 32'(digits[7:4]), 32'd2);
    hold(4'b0010, 7'b1010100, SC);
    step(4'b0010, 7'b1010100, 1'b1);
    check("err1_set_wins", 32'(err[1]), 32'd1);
    step(4'b0010, 7'b1010100, 1'b1);
    check("err_cleared", 32'(err), 32'd0);

    // Zero and multi-hot strobes never capture.
    obs_valid = 0;
    snap_digits = digits; snap_blank = blank;
    hold(4'b0000, 7'b0000110, 10);
    hold(4'b0110, 7'b0000110, 10);
    check("badstrobe_valid", 32'(obs_valid), 32'd0);
    check("badstrobe_digits", 32'(digits), 32'(snap_digits));
    check("badstrobe_blank", 32'(blank), 32'(snap_blank));

    // Randomized scans with glitches, clears, odd strobes and resets.
    for (int ph = 0; ph < 250; ph++) begin
      logic [ND-1:0] en;
      logic [6:0]    seg, s;
      int            len;
      if ($urandom_range(0, 99) < 85) en = ND'(1) << $urandom_range(0, ND - 1);
      else en = ND'($urandom);
      case ($urandom_range(0, 9))
        0:       seg = 7'h7f;
        1, 2:    seg = 7'($urandom);
        default: seg = pat_tab[$urandom_range(0, 9)];
      endcase
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        s = seg;
        if ($urandom_range(0, 99) < 8) s = seg ^ (7'd1 << $urandom_range(0, 6));
        step(en, s, $urandom_range(0, 99) < 10);
      end
      if ($urandom_range(0, 99) < 3) async_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_pattern_reader.md
Name: seg_pattern_reader

Overview:
Receiving end of the multiplexed 7-segment display interface. It samples the active-low segment bus and the one-hot digit strobe, waits until each strobed pattern is stable, and decodes the pattern back into a 4-bit BCD value per digit. It then publishes per-digit values, blank and error flags, and an update/frame handshake. It is used for display loop-back checking and for readback of processor output digits.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (strobe width, 1..8)
STABLE_CYCLES, 4, consecutive unchanged cycles required before capture (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
seg_n  in  7  segment bus {a,b,c,d,e,f,g}, a = MSB, 0 = segment lit; synchronous to clk
digit_en  in  NUM_DIGITS  digit strobe, one-hot, active-high; synchronous to clk
err_clr  in  1  clears the sticky error mask
digits  out  4*NUM_DIGITS  captured BCD values; digit i occupies bits [4i+3:4i]
blank  out  NUM_DIGITS  bit i = digit i last captured as all-off (7'b1111111)
err  out  NUM_DIGITS  sticky: digit i captured a non-decodable pattern
upd_valid  out  1  one-cycle pulse: a capture just completed
upd_digit  out  3  index of the captured digit, valid with upd_valid
upd_value  out  4  decoded value, valid with upd_valid (0 if blank or error)
frame_done  out  1  one-cycle pulse: every digit captured at least once since the last pulse

Behaviour:
- Clocking and reset: one clock. rst is asynchronous and active-high.
- Reset values: digits=0, blank=all ones, err=0, upd_valid=0, upd_digit=0, upd_value=0, frame_done=0. Also reset: stability counter=0, captured mask=0, state=IDLE, sample register=all ones.
- Reset asserted mid-settle or mid-hold aborts the capture. No upd_valid is produced for the interrupted sample.
- Sample register s_q holds {digit_en, seg_n} from the previous edge. "Match" means the current inputs equal s_q.
- Decode table (seg_n to value):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
  - 1111111=blank
  - any other pattern = error
- State machine:
  - IDLE: digit_en is not one-hot (zero or multi-hot). The counter is held at 0. On an edge where digit_en is one-hot: go to SETTLE, counter=1.
  - SETTLE: on a match, counter+1. On a mismatch with a one-hot strobe, counter=1 and stay in SETTLE. On a non-one-hot strobe, go to IDLE. When the counter reaches STABLE_CYCLES on a match edge, capture and go to HOLD.
  - HOLD: no further captures. Any mismatch goes to SETTLE (counter=1) if the strobe is one-hot, else to IDLE.
- Latency: with inputs applied before edge 0 and held, capture occurs at edge STABLE_CYCLES. upd_valid is high for exactly the cycle following that edge. With STABLE_CYCLES=1, upd_valid follows edge 1.
- Capture on digit i, all effective at the same edge:
  - Write digits[i].
  - Write blank[i]: 1 if blank, else 0.
  - On error: set err[i] and leave digits[i] unchanged.
  - Set captured bit i.
  - Drive upd_digit=i and upd_value.
- Re-capturing the same digit with an identical pattern still pulses upd_valid.
- frame_done pulses in the same cycle as the upd_valid that completes the captured mask (all ones). The mask clears at that edge. NUM_DIGITS=1 gives frame_done on every capture.
- err_clr clears all err bits at the next edge. If a new error on digit i occurs at the same edge, the set wins for err[i].
- A single-cycle glitch on seg_n restarts the counter. No capture occurs unless the pattern is held for the full window.
- Width rules: upd_digit is the zero-extended one-hot-to-binary index. Unused upd_digit bits are 0.

Decomposition:
- Shared package seg_pkg:
  - SEG_0..SEG_9 and SEG_BLANK 7-bit constants, in the same bit order and polarity as the display driver.
  - Reader state enum {IDLE, SETTLE, HOLD}.
- One combinational sub-module, seg_pattern_decode:
  - Input: 7-bit pattern.
  - Outputs: 4-bit value, blank, invalid.
  - Reusable by other display checkers.

Test Plan:
- Reset: assert rst asynchronously mid-SETTLE with digit 2 strobed and seg_n=0010010 -> all outputs at reset values immediately; no upd_valid after release until a fresh STABLE_CYCLES+1 edges have passed.
- Basic capture: digit_en=0001, seg_n=0000110 held for 5 edges (STABLE_CYCLES=4) -> upd_valid after edge 4 only, upd_digit=0, upd_value=3, digits[3:0]=3, blank[0]=0.
- Full frame: scan digits 0..3 with values 1,2,8,9, each held 6 cycles -> 4 upd_valid pulses; frame_done coincides with the digit 3 pulse; digits=16'h9821; blank=0000.
- Glitch/stability: seg_n=0100100 held 3 cycles, 1-cycle flip to 0000000, then held 0100100 -> no capture until 4 consecutive matches after the glitch; captured value=5.
- Blank and error: digit 1 strobed with 1111111 -> blank[1]=1, upd_value=0. Digit 1 then strobed with 1010101 -> err[1]=1, digits[7:4] unchanged. err_clr together with a new error on digit 1 -> err[1] stays 1.
- Bad strobe: digit_en=0000, then 0110, each held 10 cycles -> no upd_valid; state stays IDLE; outputs unchanged.
